// File: rtl/cpu_pkg.sv
// Shared pipeline types: opcodes, forward-select encoding, scoreboard entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_wr;
        logic       is_load;
    } sb_entry_t;

    // An entry produces r when it will write r; x0 is never a real destination.
    function automatic logic produces(input sb_entry_t e, input logic [4:0] r);
        return e.valid & e.reg_wr & (e.rd == r) & (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM destination tracking plus RAW hazard and forward-source compare.
// Latency: hazard and next forward selects are combinational; entries advance on each non-held edge.
// Backpressure: hold (memory freeze) keeps both entries unchanged. HAZ_FWD_EN selects load-use-only rules.
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       id_ent_vld,
    input  logic [4:0] id_rd,
    input  logic       id_reg_wr,
    input  logic       id_is_load,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hazard
`ifdef HAZ_FWD_EN
    ,
    output logic [1:0] fwd_a_nxt,
    output logic [1:0] fwd_b_nxt
`endif
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;

    // Hazard on one operand under the compiled-in forwarding policy.
    function automatic logic op_hazard(input sb_entry_t ex_e, input sb_entry_t mem_e,
                                       input logic [4:0] r, input logic use_r);
`ifdef HAZ_FWD_EN
        // Only a load in EX cannot be forwarded in time; MEM producers are always covered.
        return use_r & produces(ex_e, r) & ex_e.is_load;
`else
        // WB writes through the register file, so only EX and MEM producers matter.
        return use_r & (produces(ex_e, r) | produces(mem_e, r));
`endif
    endfunction

    // Shift ID -> EX -> MEM unless the whole pipeline is frozen.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!hold) begin
            mem_d = ex_q;
            ex_d  = '{valid: id_ent_vld, rd: id_rd, reg_wr: id_reg_wr, is_load: id_is_load};
        end
    end

    // Shadow entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    // RAW hazard against the instruction currently in ID.
    always_comb begin
        hazard = op_hazard(ex_q, mem_q, id_rs1, id_use_rs1) |
                 op_hazard(ex_q, mem_q, id_rs2, id_use_rs2);
    end

`ifdef HAZ_FWD_EN
    // Source the ID instruction will need once it sits in EX; the youngest producer wins.
    function automatic logic [1:0] fwd_pick(input sb_entry_t ex_e, input sb_entry_t mem_e,
                                            input logic vld, input logic [4:0] r,
                                            input logic use_r);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (vld && use_r) begin
            if (produces(ex_e, r) && !ex_e.is_load)
                sel = FWD_MEM;
            else if (produces(mem_e, r))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    // Next forward selects; a bubble or flush entering EX gets the register file.
    always_comb begin
        fwd_a_nxt = fwd_pick(ex_q, mem_q, id_ent_vld, id_rs1, id_use_rs1);
        fwd_b_nxt = fwd_pick(ex_q, mem_q, id_ent_vld, id_rs2, id_use_rs2);
    end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/bubble, redirect flush, memory freeze, forward selects.
// Latency: stall/flush/freeze combinational (0 cycles); fwd selects and counters registered (1 cycle).
// Backpressure: mem_busy freezes everything and masks stall/flush; HAZ_FWD_EN enables forwarding.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_wr,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             freeze,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic hazard;
    logic stall;
    logic redirect;
    logic id_ent_vld;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Freeze masks everything; a redirect kills the ID instruction and so beats its stall.
    always_comb begin
        freeze     = mem_busy;
        redirect   = ~mem_busy & ex_redirect;
        stall      = ~mem_busy & id_valid & hazard & ~ex_redirect;
        stall_if   = stall;
        stall_id   = stall;
        bubble_ex  = stall | redirect;
        flush_id   = redirect;
        id_ent_vld = id_valid & ~stall & ~redirect;
    end

`ifdef HAZ_FWD_EN
    logic [1:0] fwd_a_nxt, fwd_b_nxt;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
`endif

    hazard_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (mem_busy),
        .id_ent_vld (id_ent_vld),
        .id_rd      (id_rd),
        .id_reg_wr  (id_reg_wr),
        .id_is_load (id_is_load),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hazard     (hazard)
`ifdef HAZ_FWD_EN
        ,
        .fwd_a_nxt  (fwd_a_nxt),
        .fwd_b_nxt  (fwd_b_nxt)
`endif
    );

`ifdef HAZ_FWD_EN
    // Forward selects advance with the pipeline and hold while frozen.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!mem_busy) begin
            fwd_a_d = fwd_a_nxt;
            fwd_b_d = fwd_b_nxt;
        end
    end

    // Forward select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // Saturating event counters; stall and redirect are already masked by freeze.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB). It tracks the destination registers of in-flight instructions and detects RAW hazards against the instruction in ID. It drives PC/IF-ID hold, EX bubble insertion, flush on EX-resolved redirects and global freeze on memory back-pressure. With forwarding compiled in, it also produces registered operand-forward selects for EX.

## Interface
Parameters:
- CNT_W, 16, width of saturating performance counters

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_rs1, id_rs2  in  5  source register indices of ID instruction
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- id_rd  in  5  destination register of ID instruction
- id_reg_wr  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load (opcode 0000011)
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- mem_busy  in  1  memory unit not ready; whole pipeline must hold
- freeze  out  1  hold every pipeline register and PC
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_id  out  1  replace IF/ID contents with NOP
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 0 regfile, 1 MEM result, 2 WB data (registered)
- stall_cnt  out  CNT_W  cycles with hazard stall asserted
- flush_cnt  out  CNT_W  redirects taken

## Operation
- Shadow scoreboard: two entries, EX and MEM, each {valid, rd, reg_wr, is_load}. On each non-frozen edge, MEM <= EX and EX <= ID entry. The ID entry is invalid when bubble_ex or flush is asserted or id_valid=0.
- Entry "produces r" iff valid & reg_wr & rd==r & r!=0. x0 never creates a hazard.
- Register file writes in WB are visible to same-cycle ID reads (write-through), so WB-stage producers never cause a hazard.
- Hazard on operand s (s = rs1 with id_use_rs1, or rs2 with id_use_rs2):
  - Forwarding on: hazard only if the EX entry produces s and is_load (load-use).
  - Forwarding off: hazard if the EX or MEM entry produces s.
- stall = id_valid & hazard & ~ex_redirect. stall drives stall_if=stall_id=bubble_ex=1.
- Redirect: ex_redirect=1 gives flush_id=1 and bubble_ex=1, and clears the ID entry. Redirect overrides any stall. The PC load comes from the datapath.
- Freeze: mem_busy=1 gives freeze=1. stall_if/stall_id/bubble_ex/flush_id are forced 0. Shadow registers, fwd selects and counters hold. ex_redirect is ignored while frozen; the datapath holds it stable.
- Forward select (forwarding on), computed per operand from ID and registered on non-frozen edges:
  - 1 if the current EX entry produces s and is not a load;
  - else 2 if the current MEM entry produces s, or a stalled load producer is now in MEM;
  - else 0.
  - Youngest producer wins.
  - Bubble/flush cycles register 0.
- Counters saturate at all-ones. stall_cnt increments on each non-frozen stall cycle. flush_cnt increments on each non-frozen redirect.

## Timing
- stall/flush/freeze outputs are combinational from inputs and shadow registers, with zero latency.
- fwd_*_sel and counters are registered, with one-cycle latency.
- Load-use with forwarding: exactly 1 stall cycle. Non-load RAW with forwarding: 0 cycles.
- Without forwarding, RAW distance 1 → 2 stall cycles; distance 2 → 1 stall cycle.
- Redirect: the two younger instructions (IF/ID, ID/EX) are killed in the same cycle. Refill penalty is 2 cycles.
- Reset (asynchronous, any time): shadow entries invalid, fwd selects 0, counters 0. All combinational outputs are consequently 0 with inputs low.

## Configuration
- HAZ_FWD_EN defined: forwarding hazard rules apply, and fwd_*_sel registers are generated.
- HAZ_FWD_EN undefined: full-stall rules apply, and fwd_*_sel are tied to 0. The MEM entry participates in hazard detection.

## Structure
- cpu_pkg holds:
  - opcode constants (OP_R 0110011, OP_I 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111);
  - fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB);
  - sb_entry_t struct {valid, rd, reg_wr, is_load}.
- One sub-module: hazard_scoreboard, containing the shadow entries plus the produces/hazard compare. The top adds the redirect/freeze arbitration, forward registers and counters.

## Test plan
- **Load-use:** `lw x5` followed by `add x6,x5,x1` → stall_if/stall_id/bubble_ex high for 1 cycle, then fwd_a_sel=2 in EX for the add. stall_cnt=1.
- **ALU chain:** `add x5`, `sub x7,x5,x5` → no stall, fwd_a_sel=fwd_b_sel=1. Distance 2 → sel=2.
- **HAZ_FWD_EN off, same chain:** 2 stall cycles, then 1 for distance 2. fwd selects stay 0.
- **Redirect during load-use stall:** ex_redirect=1 → stall 0, flush_id=1, bubble_ex=1, flush_cnt +1. x0 destination never stalls.
- **Freeze:** mem_busy=1 for 3 cycles mid load-use → freeze=1, stall outputs 0, counters and shadows unchanged. After release, the stall completes as normal.
- **Reset and saturation:** rst_n low asynchronously mid-stall → all outputs 0 immediately. With CNT_W=4, 20 stalls → stall_cnt=15.
